sprite_mover: RTL and testbench
===============================

Name: sprite_mover

Overview:
- Parametrised obstacle engine for the VGA plot interface.
- Draws a solid OBJ_W x OBJ_H rectangle, waits a programmable number of frame ticks, erases it, steps it horizontally, and redraws.
- Adds direction control, wrap or stop at the edges, pause, and a done handshake.
- Sits between the game control FSM and the VGA adapter's x/y/colour/plot inputs.

Parameters:
OBJ_W, 4, sprite width in pixels (1..16)
OBJ_H, 4, sprite height in pixels (1..16)
START_X, 10, left-top x after reset/restart
START_Y, 58, left-top y (fixed for the block's lifetime)
MIN_X, 10, lowest legal left-top x
MAX_X, 100, highest legal left-top x
STEP, 1, pixels moved per step (1..15)
FG_COLOUR, 3'd2, sprite colour
BG_COLOUR, 3'd0, erase colour
TICKS_PER_FRAME, 833333, clocks per frame tick (50 MHz / 60)
FRAMES_PER_STEP, 15, frame ticks per movement step

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  single-cycle pulse; starts from IDLE, restarts from DONE, ignored elsewhere
pause  in  1  level; freezes the frame and step counters while high
dir  in  1  0 = move right (+x), 1 = move left (-x); sampled in MOVE
wrap  in  1  1 = wrap at the edge, 0 = stop at the edge; sampled in MOVE
x  out  8  pixel x to the VGA adapter
y  out  7  pixel y to the VGA adapter
colour  out  3  pixel colour
plot  out  1  pixel write strobe
busy  out  1  high in every state except IDLE and DONE
finish  out  1  high while in DONE

Behaviour:
- Clock and reset: one clock domain named "clock". reset is synchronous and active-high; it is sampled on the posedge clock.
- Reset values:
  - State = IDLE.
  - pos_x = START_X, pos_y = START_Y.
  - x = 0, y = 0, colour = 0, plot = 0, busy = 0, finish = 0.
  - All counters = 0.
- Outputs are registered.
- States and transitions:
  - IDLE -> DRAW on go.
  - DRAW -> WAIT after OBJ_W*OBJ_H plot cycles.
  - WAIT -> ERASE when the step interval expires.
  - ERASE -> MOVE after OBJ_W*OBJ_H plot cycles.
  - MOVE -> DRAW, or MOVE -> DONE.
  - DONE -> DRAW on go, with pos_x reloaded to START_X.
- DRAW and ERASE:
  - A raster counter (col, row) scans row-major, col fastest, starting at (0,0).
  - Each cycle outputs plot = 1, x = pos_x + col, y = pos_y + row.
  - colour = FG_COLOUR in DRAW, BG_COLOUR in ERASE.
  - plot is high for exactly OBJ_W*OBJ_H consecutive cycles, then 0 on the first WAIT or MOVE cycle.
  - Address sums are truncated to the output widths; MAX_X + OBJ_W - 1 <= 159 is a parameter constraint and is not checked.
- WAIT:
  - Both counters clear on entry.
  - The tick counter counts clocks; one frame tick fires when it reaches TICKS_PER_FRAME - 1, and the counter then clears.
  - The frame counter counts ticks; the step interval expires on tick FRAMES_PER_STEP.
  - With pause low throughout, WAIT lasts exactly TICKS_PER_FRAME*FRAMES_PER_STEP cycles.
  - pause high holds both counters. DRAW and ERASE are never paused.
- MOVE lasts one cycle, plot = 0. dir and wrap are sampled here.
  - Right move: if pos_x + STEP > MAX_X, then pos_x = MIN_X when wrap = 1, or state = DONE when wrap = 0. Otherwise pos_x += STEP.
  - Left move: if pos_x < MIN_X + STEP, then pos_x = MAX_X when wrap = 1, or state = DONE when wrap = 0. Otherwise pos_x -= STEP.
  - Comparisons use 9-bit arithmetic, so the sums do not overflow.
- DONE: the sprite stays erased. finish = 1 and busy = 0, held until go or reset.
- Simultaneous events:
  - reset has priority over everything.
  - go while busy is ignored.
  - A pause change during MOVE has no effect.
- Reset mid-DRAW/ERASE: the next cycle has plot = 0 and state = IDLE. Partially drawn pixels are not cleaned up; the screen-clear logic owns that.

Test Plan:
All scenarios use OBJ_W = 2, OBJ_H = 2, STEP = 1, MIN_X = 10, MAX_X = 12, START_X = 10, START_Y = 58, TICKS_PER_FRAME = 4, FRAMES_PER_STEP = 2.
1. Reset, then go pulse -> 4 plot cycles at (10,58), (11,58), (10,59), (11,59) with colour = 2, busy = 1, then plot = 0 for exactly 8 WAIT cycles.
2. Continue with dir = 0, wrap = 0 -> erase at x 10/11 with colour 0, MOVE, redraw at x 11/12. After the sprite reaches pos_x = 12, the next MOVE gives finish = 1 and busy = 0. A go pulse then redraws at pos_x = 10.
3. dir = 0, wrap = 1 from pos_x = 12 -> the next draw is at pos_x = 10 and finish stays 0. dir = 1, wrap = 1 from pos_x = 10 -> the next draw is at pos_x = 12.
4. pause high for 20 cycles in the middle of WAIT -> WAIT lasts 28 cycles in total and plot stays 0 throughout.
5. reset asserted on the 3rd DRAW cycle -> the next cycle has plot = 0, busy = 0, and all outputs at their reset values. A go pulse 1 cycle later restarts the draw at (10,58).
6. go pulsed during WAIT and during ERASE -> no state change and identical cycle timing to scenario 1.

Source files
------------

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_mover
//  Description : Obstacle engine for the VGA plot interface. Draws a solid
//                OBJ_W x OBJ_H rectangle, waits a number of frame ticks,
//                erases it, steps it horizontally, and redraws. Supports
//                direction control, wrap/stop at the edges, pause, and a
//                done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_mover #(
    parameter int         OBJ_W           = 4,
    parameter int         OBJ_H           = 4,
    parameter int         START_X         = 10,
    parameter int         START_Y         = 58,
    parameter int         MIN_X           = 10,
    parameter int         MAX_X           = 100,
    parameter int         STEP            = 1,
    parameter logic [2:0] FG_COLOUR       = 3'd2,
    parameter logic [2:0] BG_COLOUR       = 3'd0,
    parameter int         TICKS_PER_FRAME = 833333,
    parameter int         FRAMES_PER_STEP = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       go,
    input  logic       pause,
    input  logic       dir,
    input  logic       wrap,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       finish
);

    // Counter widths; a single-clock frame still needs a 1-bit tick counter.
    localparam int c_TW = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int c_FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [c_TW-1:0] c_TICK_LAST  = c_TW'(TICKS_PER_FRAME - 1);
    localparam logic [c_FW-1:0] c_FRAME_LAST = c_FW'(FRAMES_PER_STEP - 1);
    localparam logic [3:0]      c_COL_LAST   = 4'(OBJ_W - 1);
    localparam logic [3:0]      c_ROW_LAST   = 4'(OBJ_H - 1);
    localparam logic [7:0]      c_START_X    = 8'(START_X);
    localparam logic [6:0]      c_START_Y    = 7'(START_Y);
    localparam logic [7:0]      c_MIN_X      = 8'(MIN_X);
    localparam logic [7:0]      c_MAX_X      = 8'(MAX_X);
    localparam logic [7:0]      c_STEP       = 8'(STEP);
    // 9-bit copies so edge tests cannot overflow.
    localparam logic [8:0]      c_MIN_X9     = 9'(MIN_X);
    localparam logic [8:0]      c_MAX_X9     = 9'(MAX_X);
    localparam logic [8:0]      c_STEP9      = 9'(STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic [3:0]      r_col,    w_col_nxt;
    logic [3:0]      r_row,    w_row_nxt;
    logic [c_TW-1:0] r_tick,   w_tick_nxt;
    logic [c_FW-1:0] r_frame,  w_frame_nxt;
    logic [7:0]      r_pos_x,  w_pos_x_nxt;

    logic [7:0]      r_x,      w_x_nxt;
    logic [6:0]      r_y,      w_y_nxt;
    logic [2:0]      r_colour, w_colour_nxt;
    logic            r_plot,   w_plot_nxt;
    logic            r_busy,   w_busy_nxt;
    logic            r_finish, w_finish_nxt;

    logic            w_raster_last;
    logic [8:0]      w_right_sum;
    logic [8:0]      w_left_limit;

    assign w_raster_last = (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    assign w_right_sum   = {1'b0, r_pos_x} + c_STEP9;
    assign w_left_limit  = c_MIN_X9 + c_STEP9;

    // State register, counters and position.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_tick  <= '0;
            r_frame <= '0;
            r_pos_x <= c_START_X;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_tick  <= w_tick_nxt;
            r_frame <= w_frame_nxt;
            r_pos_x <= w_pos_x_nxt;
        end
    end

    // Next-state, raster/wait counters and edge handling.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_tick_nxt  = r_tick;
        w_frame_nxt = r_frame;
        w_pos_x_nxt = r_pos_x;
        case (r_state)
            S_IDLE: begin
                if (go) begin
                    w_state_nxt = S_DRAW;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            S_DRAW, S_ERASE: begin
                if (w_raster_last) begin
                    w_state_nxt = (r_state == S_DRAW) ? S_WAIT : S_MOVE;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_tick_nxt  = '0;
                    w_frame_nxt = '0;
                end else if (r_col == c_COL_LAST) begin
                    w_col_nxt = '0;
                    w_row_nxt = r_row + 4'd1;
                end else begin
                    w_col_nxt = r_col + 4'd1;
                end
            end
            S_WAIT: begin
                if (!pause) begin
                    if (r_tick == c_TICK_LAST) begin
                        w_tick_nxt = '0;
                        if (r_frame == c_FRAME_LAST) begin
                            w_frame_nxt = '0;
                            w_state_nxt = S_ERASE;
                            w_col_nxt   = '0;
                            w_row_nxt   = '0;
                        end else begin
                            w_frame_nxt = r_frame + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                end
            end
            S_MOVE: begin
                w_state_nxt = S_DRAW;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
                if (!dir) begin
                    if (w_right_sum > c_MAX_X9) begin
                        if (wrap) w_pos_x_nxt = c_MIN_X;
                        else      w_state_nxt = S_DONE;
                    end else begin
                        w_pos_x_nxt = w_right_sum[7:0];
                    end
                end else begin
                    if ({1'b0, r_pos_x} < w_left_limit) begin
                        if (wrap) w_pos_x_nxt = c_MAX_X;
                        else      w_state_nxt = S_DONE;
                    end else begin
                        w_pos_x_nxt = r_pos_x - c_STEP;
                    end
                end
            end
            S_DONE: begin
                if (go) begin
                    w_state_nxt = S_DRAW;
                    w_pos_x_nxt = c_START_X;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so the registered
    // outputs line up with the state they describe.
    always_comb begin
        w_plot_nxt   = (w_state_nxt == S_DRAW) || (w_state_nxt == S_ERASE);
        w_busy_nxt   = (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
        w_finish_nxt = (w_state_nxt == S_DONE);
        w_x_nxt      = '0;
        w_y_nxt      = '0;
        w_colour_nxt = '0;
        if (w_plot_nxt) begin
            w_x_nxt      = w_pos_x_nxt + {4'b0000, w_col_nxt};
            w_y_nxt      = c_START_Y + {3'b000, w_row_nxt};
            w_colour_nxt = (w_state_nxt == S_DRAW) ? FG_COLOUR : BG_COLOUR;
        end
    end

    // Registered pixel and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_colour <= w_colour_nxt;
            r_plot   <= w_plot_nxt;
            r_busy   <= w_busy_nxt;
            r_finish <= w_finish_nxt;
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_mover
//  Description : Directed self-checking bench for sprite_mover using a
//                2x2 sprite on a 10..12 track with 8-cycle wait intervals.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mover;

    logic       clock = 1'b0;
    logic       reset;
    logic       go;
    logic       pause;
    logic       dir;
    logic       wrap;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       finish;

    int n_tests = 0;
    int n_fail  = 0;

    sprite_mover #(
        .OBJ_W           (2),
        .OBJ_H           (2),
        .START_X         (10),
        .START_Y         (58),
        .MIN_X           (10),
        .MAX_X           (12),
        .STEP            (1),
        .FG_COLOUR       (3'd2),
        .BG_COLOUR       (3'd0),
        .TICKS_PER_FRAME (4),
        .FRAMES_PER_STEP (2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .go     (go),
        .pause  (pause),
        .dir    (dir),
        .wrap   (wrap),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot),
        .busy   (busy),
        .finish (finish)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; sample just after the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check_status(input string tag, input int p, input int b, input int f);
        check_eq({tag, ".plot"},   32'(plot),   32'(p));
        check_eq({tag, ".busy"},   32'(busy),   32'(b));
        check_eq({tag, ".finish"}, 32'(finish), 32'(f));
    endtask

    // Four raster pixels of a 2x2 sprite at left-top (px,58).
    task automatic expect_raster(input string tag, input int px, input int c);
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, ".x"},      32'(x),      32'(px + (i % 2)));
            check_eq({tag, ".y"},      32'(y),      32'(58 + (i / 2)));
            check_eq({tag, ".colour"}, 32'(colour), 32'(c));
            check_status(tag, 1, 1, 0);
            cyc();
        end
    endtask

    task automatic expect_wait(input int n);
        for (int i = 0; i < n; i++) begin
            check_status("wait", 0, 1, 0);
            cyc();
        end
    endtask

    task automatic expect_move();
        check_status("move", 0, 1, 0);
        cyc();
    endtask

    task automatic full_step(input int px);
        expect_raster("draw", px, 2);
        expect_wait(8);
        expect_raster("erase", px, 0);
        expect_move();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        pause = 1'b0;
        dir   = 1'b0;
        wrap  = 1'b0;
        cyc();
        cyc();
        // Reset values.
        check_eq("rst.x",      32'(x),      32'd0);
        check_eq("rst.y",      32'(y),      32'd0);
        check_eq("rst.colour", 32'(colour), 32'd0);
        check_status("rst", 0, 0, 0);
        reset = 1'b0;
        cyc();
        check_status("idle", 0, 0, 0);

        // Scenarios 1 and 2: walk right with stop at the edge.
        go = 1'b1;
        cyc();
        go = 1'b0;
        full_step(10);
        full_step(11);
        full_step(12);
        check_status("done", 0, 0, 1);
        cyc();
        check_status("done_hold", 0, 0, 1);
        go = 1'b1;
        cyc();
        go = 1'b0;

        // Scenario 3: right wrap from 12 to 10, then left wrap from 10 to 12.
        wrap = 1'b1;
        full_step(10);
        full_step(11);
        full_step(12);
        check_eq("wrap_r.finish", 32'(finish), 32'd0);
        dir = 1'b1;
        full_step(10);

        // Scenario 4: pause for 20 cycles inside WAIT.
        expect_raster("draw_p", 12, 2);
        expect_wait(3);
        pause = 1'b1;
        expect_wait(20);
        pause = 1'b0;
        expect_wait(5);
        expect_raster("erase_p", 12, 0);
        expect_move();

        // Scenario 5: reset on the third draw cycle at x=11.
        check_eq("pre_rst.x0", 32'(x), 32'd11);
        cyc();
        check_eq("pre_rst.x1", 32'(x), 32'd12);
        cyc();
        check_eq("pre_rst.plot", 32'(plot), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check_eq("mid_rst.x",      32'(x),      32'd0);
        check_eq("mid_rst.y",      32'(y),      32'd0);
        check_eq("mid_rst.colour", 32'(colour), 32'd0);
        check_status("mid_rst", 0, 0, 0);
        cyc();
        check_status("mid_rst_idle", 0, 0, 0);
        go = 1'b1;
        cyc();
        go = 1'b0;

        // Scenario 6: go pulses in WAIT and ERASE are ignored.
        expect_raster("draw_g", 10, 2);
        expect_wait(2);
        go = 1'b1;
        expect_wait(1);
        go = 1'b0;
        expect_wait(5);
        go = 1'b1;
        expect_raster("erase_g", 10, 0);
        go = 1'b0;
        expect_move();
        expect_raster("draw_lw", 12, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
